sort_stream_ctrl: RTL and testbench

Stream-side sequencer for the in-place RAM sorter. It accepts 2**ADDR_WIDTH words on a valid/ready input stream and writes them into the sorter RAM through the sorter's external write port. It then raises the sorter start line and waits for done. Once the sorter finishes, it reads the sorted array back out on a valid/ready output stream. It sits between the upstream data producer and the sorter, and owns every sorter control pin.

---
 rtl/sort_stream_ctrl.sv | 144 ++++++++++++++
 tb/tb_sort_stream_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: loads one block into the RAM sorter, starts it, then streams the sorted block out.
// Optional build macro SORT_DESCEND_EN: read the block back largest-first instead of smallest-first.
module sort_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] srt_radd,
    output logic [DATA_WIDTH-1:0] srt_datain,
    output logic                  srt_wrin,
    output logic                  srt_rd,
    output logic                  srt_s,
    input  logic                  srt_done,
    input  logic [DATA_WIDTH-1:0] srt_dout
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {LOAD, START, WAIT, RELEASE, RADDR, RDATA} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_radd;
    logic [DATA_WIDTH-1:0] r_datain;
    logic                  r_wrin;
    logic                  r_rd;
    logic                  r_s;

    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_last;
    logic [ADDR_WIDTH:0]   w_cnt_next;

    assign w_in_hs    = in_valid & r_in_ready;
    assign w_out_hs   = r_out_valid & out_ready;
    assign w_last     = (r_cnt == LAST_CNT);
    assign w_cnt_next = r_cnt + 1'b1;

    // The sorter leaves the RAM ascending, so descending order just walks the addresses backwards.
    function automatic logic [ADDR_WIDTH-1:0] readAddr(input logic [ADDR_WIDTH-1:0] c);
`ifdef SORT_DESCEND_EN
        return ADDR_WIDTH'(DEPTH - 1) - c;
`else
        return c;
`endif
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= LOAD;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_radd      <= '0;
            r_datain    <= '0;
            r_wrin      <= 1'b0;
            r_rd        <= 1'b0;
            r_s         <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_in_ready <= 1'b1;
                    r_wrin     <= 1'b0;
                    if (w_in_hs) begin
                        r_radd   <= r_cnt[ADDR_WIDTH-1:0];
                        r_datain <= in_data;
                        r_wrin   <= 1'b1;
                        r_cnt    <= w_cnt_next;
                        r_busy   <= 1'b1;
                        if (w_last) begin
                            r_in_ready <= 1'b0;
                            r_state    <= START;
                        end
                    end
                end
                START: begin
                    r_wrin  <= 1'b0;
                    r_s     <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (srt_done) begin
                        r_s     <= 1'b0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_cnt   <= '0;
                    r_rd    <= 1'b1;
                    r_radd  <= readAddr('0);
                    r_state <= RADDR;
                end
                // Sorter read data is valid while the address is presented, so capture on leaving RADDR.
                RADDR: begin
                    r_out_data  <= srt_dout;
                    r_out_valid <= 1'b1;
                    r_state     <= RDATA;
                end
                RDATA: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_cnt      <= '0;
                            r_rd       <= 1'b0;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= LOAD;
                        end else begin
                            r_cnt   <= w_cnt_next;
                            r_radd  <= readAddr(w_cnt_next[ADDR_WIDTH-1:0]);
                            r_state <= RADDR;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign srt_radd   = r_radd;
    assign srt_datain = r_datain;
    assign srt_wrin   = r_wrin;
    assign srt_rd     = r_rd;
    assign srt_s      = r_s;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: behavioural RAM sorter, block-level reference model and literal result checks.
// Honours SORT_DESCEND_EN the same way the design does.
`timescale 1ns/1ps
module tb_sort_stream_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int SORT_LAT = 6;

    typedef logic [DW-1:0] blk_t [DEPTH];

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic [AW-1:0] srt_radd;
    logic [DW-1:0] srt_datain;
    logic          srt_wrin;
    logic          srt_rd;
    logic          srt_s;
    logic          srt_done = 1'b0;
    logic [DW-1:0] srt_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy),
        .srt_radd(srt_radd), .srt_datain(srt_datain), .srt_wrin(srt_wrin),
        .srt_rd(srt_rd), .srt_s(srt_s), .srt_done(srt_done), .srt_dout(srt_dout)
    );

    // Sorter stand-in: RAM written while idle, sorted ascending some cycles after start, done held until s drops.
    logic [DW-1:0] sMem [DEPTH];
    logic [DW-1:0] sTmp [DEPTH];
    logic [DW-1:0] sSwap;
    int            sTimer = 0;

    always @(posedge clk) begin
        if (srt_wrin && !srt_s) sMem[srt_radd] <= srt_datain;
        if (!srt_s) begin
            sTimer   <= 0;
            srt_done <= 1'b0;
        end else if (sTimer == SORT_LAT) begin
            if (!srt_done) begin
                sTmp = sMem;
                for (int i = 0; i < DEPTH; i++)
                    for (int j = 0; j < DEPTH - 1 - i; j++)
                        if (sTmp[j] > sTmp[j+1]) begin
                            sSwap = sTmp[j]; sTmp[j] = sTmp[j+1]; sTmp[j+1] = sSwap;
                        end
                sMem <= sTmp;
            end
            srt_done <= 1'b1;
        end else begin
            sTimer <= sTimer + 1;
        end
    end

    assign srt_dout = srt_rd ? sMem[srt_radd] : '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void checkResetOutputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"},  32'(out_data), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_srt_radd"},  32'(srt_radd), 0);
        check({tag, "_srt_datain"}, 32'(srt_datain), 0);
        check({tag, "_srt_wrin"},  32'(srt_wrin), 0);
        check({tag, "_srt_rd"},    32'(srt_rd), 0);
        check({tag, "_srt_s"},     32'(srt_s), 0);
    endfunction

    // Reference model: a block of DEPTH accepted words becomes one sorted block of expected outputs.
    logic [DW-1:0] blk [$];
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] capQ [$];
    bit            postEdge = 1'b0;
    bit            loadPhase = 1'b1;
    bit            expBusy = 1'b0;
    int            outCount = 0;
    int            sinceLoad = 100;
    int            sinceOut = 100;
    bit            prevStall = 1'b0;
    logic [DW-1:0] prevData = '0;

    function automatic void pushSortedBlock();
        logic [DW-1:0] a [DEPTH];
        logic [DW-1:0] t;
        for (int i = 0; i < DEPTH; i++) a[i] = blk[i];
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH - 1 - i; j++)
`ifdef SORT_DESCEND_EN
                if (a[j] < a[j+1]) begin
`else
                if (a[j] > a[j+1]) begin
`endif
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < DEPTH; i++) expQ.push_back(a[i]);
        blk.delete();
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) postEdge <= 1'b0;
        else       postEdge <= 1'b1;
    end

    always @(negedge clk) begin
        if (!rstn) begin
            blk.delete();
            expQ.delete();
            loadPhase = 1'b1;
            expBusy   = 1'b0;
            outCount  = 0;
            sinceLoad = 100;
            sinceOut  = 100;
            prevStall = 1'b0;
            checkResetOutputs("in_reset");
        end else begin
            if (sinceLoad < 100) sinceLoad++;
            if (sinceOut < 100) sinceOut++;
            check("in_ready", 32'(in_ready), 32'(postEdge && loadPhase));
            check("busy", 32'(busy), 32'(expBusy));
            check("wrin_while_s", 32'(srt_wrin && srt_s), 0);
            if (sinceLoad == 1) check("srt_s_load+1", 32'(srt_s), 0);
            if (sinceLoad == 2) check("srt_s_load+2", 32'(srt_s), 1);
            if (sinceOut == 1) check("out_valid_hs+1", 32'(out_valid), 0);
            if (sinceOut == 2) check("out_valid_hs+2", 32'(out_valid), 1);
            if (prevStall) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(prevData));
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                else check("out_data", 32'(out_data), 32'(expQ.pop_front()));
                capQ.push_back(out_data);
                outCount++;
                sinceOut = 0;
                if (outCount == DEPTH) begin
                    outCount  = 0;
                    sinceOut  = 100;
                    loadPhase = 1'b1;
                    expBusy   = 1'b0;
                end
            end else if (in_valid && postEdge && loadPhase) begin
                blk.push_back(in_data);
                expBusy = 1'b1;
                if (blk.size() == DEPTH) begin
                    pushSortedBlock();
                    loadPhase = 1'b0;
                    sinceLoad = 0;
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
        end
    end

    task automatic applyStimulus(input blk_t w, input int gap);
        bit got;
        for (int k = 0; k < DEPTH; k++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[k];
            got = 1'b0;
            for (int b = 0; b < 200 && !got; b++) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk); #1;
            end
            if (!got) check("load_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic receiveBlock(input int stallIdx, input bit noisy);
        bit got;
        if (stallIdx < 0 && !noisy) begin
            out_ready = 1'b1;
            got = 1'b0;
            for (int b = 0; b < 500 && !got; b++) begin
                @(posedge clk); #1;
                got = (capQ.size() >= DEPTH);
            end
            if (!got) check("drain_timeout", 0, 1);
        end else begin
            out_ready = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                in_valid = noisy && (k < DEPTH - 1) && (k % 2 == 0);
                in_data  = 8'hAA;
                got = 1'b0;
                for (int b = 0; b < 500 && !got; b++) begin
                    @(negedge clk);
                    got = out_valid;
                    if (!got) begin @(posedge clk); #1; end
                end
                if (!got) check("out_valid_timeout", 0, 1);
                @(posedge clk); #1;
                if (k == stallIdx) repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
                @(negedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic checkOutput(input string name, input blk_t e);
        logic [DW-1:0] want;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SORT_DESCEND_EN
            want = e[DEPTH-1-i];
`else
            want = e[i];
`endif
            if (capQ.size() == 0) check({name, "_missing"}, 0, 32'(want));
            else check(name, 32'(capQ.pop_front()), 32'(want));
        end
        capQ.delete();
    endtask

    blk_t vecA    = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
    blk_t vecB    = '{8'd2, 8'd2, 8'd9, 8'd0, 8'd9, 8'd2, 8'd1, 8'd1};
    blk_t vec81   = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    blk_t vecUp   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    blk_t vecDown = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    blk_t resB    = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd9, 8'd9};
    blk_t res18   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

    initial begin
        bit got;
        #1 rstn = 1'b0;
        #1 checkResetOutputs("reset_start");
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] block A, free-running");
        applyStimulus(vecA, 0);
        receiveBlock(-1, 1'b0);
        checkOutput("blockA", vecUp);
        check("in_ready_after_A", 32'(in_ready), 1);
        check("busy_after_A", 32'(busy), 0);

        $display("[TB] block B, toggling in_valid");
        applyStimulus(vecB, 1);
        receiveBlock(-1, 1'b0);
        checkOutput("blockB", resB);

        $display("[TB] block A, backpressure on 4th word");
        applyStimulus(vecA, 0);
        receiveBlock(3, 1'b0);
        checkOutput("blockA_stall", vecUp);

        $display("[TB] reset during WAIT");
        applyStimulus(vec81, 0);
        got = 1'b0;
        for (int b = 0; b < 100 && !got; b++) begin
            @(negedge clk);
            got = srt_s;
        end
        if (!got) check("srt_s_timeout", 0, 1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1 checkResetOutputs("reset_wait");
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        applyStimulus(vec81, 0);
        receiveBlock(-1, 1'b0);
        checkOutput("block81", res18);

        $display("[TB] sorted and reversed inputs with in_valid noise");
        applyStimulus(vecUp, 0);
        receiveBlock(-1, 1'b1);
        checkOutput("blockUp", vecUp);
        applyStimulus(vecDown, 2);
        receiveBlock(5, 1'b1);
        checkOutput("blockDown", vecUp);

        check("leftover_expected", 32'(expQ.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
